// File: rtl/monotonize_pkg.sv
// Shared helpers for the pipelined monotonize datapath: layer stride, register
// mask popcount and the control half of a pipeline stage record.
package monotonize_pkg;

  localparam int MAX_VARS = 10;

  // Control bits that accompany the data word through every stage.
  typedef struct packed {
    logic valid;
    logic down;
  } stage_ctrl_t;

  function automatic int stride(input int k);
    return 1 << k;
  endfunction

  function automatic int popcount(input logic [MAX_VARS-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < MAX_VARS; i++) n += int'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/monotonize_layer.sv
// One closure layer at stride 2^K: ORs each bit with its partner across
// variable K, in the direction selected by down_i.
module monotonize_layer
  import monotonize_pkg::*;
#(
  parameter int VARS = 7,
  parameter int K    = 0
) (
  input  logic                 down_i,
  input  logic [2**VARS-1:0]   data_i,
  output logic [2**VARS-1:0]   data_o
);

  localparam int W = 1 << VARS;
  localparam int S = stride(K);

  for (genvar i = 0; i < W; i++) begin : g_bit
    if ((i & S) != 0) begin : g_hi
      // Variable K is 1 here: upward closure pulls in the assignment with it cleared.
      assign data_o[i] = down_i ? data_i[i] : (data_i[i] | data_i[i-S]);
    end else begin : g_lo
      assign data_o[i] = down_i ? (data_i[i] | data_i[i+S]) : data_i[i];
    end
  end

endmodule

// File: rtl/pipelined_monotonize.sv
// Upward/downward closure over VARS variables with a register after every layer
// whose REG_MASK bit is set; valid/ready with full backpressure.
// Optional macro MONOTONIZE_CHECK_EN adds out_was_mono.
module pipelined_monotonize
  import monotonize_pkg::*;
#(
  parameter int              VARS     = 7,
  parameter logic [VARS-1:0] REG_MASK = 7'b0001000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_down,
  input  logic [2**VARS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2**VARS-1:0] out_data,
  output logic               out_down
`ifdef MONOTONIZE_CHECK_EN
  ,
  output logic               out_was_mono
`endif
);

  localparam int W = 1 << VARS;

  typedef struct packed {
    stage_ctrl_t    ctl;
    logic [W-1:0]   data;
`ifdef MONOTONIZE_CHECK_EN
    logic [W-1:0]   orig;
`endif
  } stage_t;

  // node[k] feeds layer k; node[VARS] is the output. rdy[k] is the ready seen by node[k].
  stage_t node [VARS+1];
  logic   rdy  [VARS+1];

  always_comb begin
    node[0]           = '0;
    node[0].ctl.valid = in_valid;
    node[0].ctl.down  = in_down;
    node[0].data      = in_data;
`ifdef MONOTONIZE_CHECK_EN
    node[0].orig      = in_data;
`endif
  end

  assign rdy[VARS] = out_ready;
  assign in_ready  = rdy[0];

  for (genvar k = 0; k < VARS; k++) begin : g_layer
    logic [W-1:0] lyr_data;
    stage_t       nxt_d;

    monotonize_layer #(
      .VARS (VARS),
      .K    (k)
    ) u_layer (
      .down_i (node[k].ctl.down),
      .data_i (node[k].data),
      .data_o (lyr_data)
    );

    // NOTE: the whole record is defaulted before the data override, so no field can hold a latch.
    always_comb begin
      nxt_d      = node[k];
      nxt_d.data = lyr_data;
    end

    if (REG_MASK[k]) begin : g_reg
      localparam bit IS_LAST = ((REG_MASK >> (k + 1)) == '0);
      stage_t stage_q;

      // NOTE: inner stages reset only their valid bit; the last stage also clears data so the outputs read 0.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          if (IS_LAST) stage_q <= '0;
          else         stage_q.ctl.valid <= 1'b0;
        end else if (rdy[k]) begin
          stage_q <= nxt_d;
        end
      end

      assign node[k+1] = stage_q;
      assign rdy[k]    = !stage_q.ctl.valid || rdy[k+1];
    end else begin : g_comb
      assign node[k+1] = nxt_d;
      assign rdy[k]    = rdy[k+1];
    end
  end

  assign out_valid = node[VARS].ctl.valid;
  assign out_down  = node[VARS].ctl.down;
  assign out_data  = node[VARS].data;

`ifdef MONOTONIZE_CHECK_EN
  // Gated by valid so the reset state (data and copy both zero) reads as 0.
  assign out_was_mono = node[VARS].ctl.valid && (node[VARS].orig == node[VARS].data);
`endif

endmodule

// File: tb/tb_pipelined_monotonize.sv
// Directed bench for pipelined_monotonize: default mask (L=1) with handshake
// scenarios, plus all-combinational (L=0) and fully registered (L=7) instances.
module tb_pipelined_monotonize;
  import monotonize_pkg::*;

  localparam int         VARS      = 7;
  localparam int         W         = 128;
  localparam logic [6:0] MASK_MAIN = 7'b0001000;
  localparam logic [6:0] MASK_COMB = 7'd0;
  localparam logic [6:0] MASK_FULL = 7'h7F;
  localparam int         L_MAIN    = popcount(10'(MASK_MAIN));
  localparam int         L_FULL    = popcount(10'(MASK_FULL));

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         in_valid, in_ready, in_down, out_valid, out_ready, out_down;
  logic [W-1:0] in_data, out_data;
  logic         c_in_valid, c_in_ready, c_in_down, c_out_valid, c_out_ready, c_out_down;
  logic [W-1:0] c_in_data, c_out_data;
  logic         f_in_valid, f_in_ready, f_in_down, f_out_valid, f_out_ready, f_out_down;
  logic [W-1:0] f_in_data, f_out_data;
`ifdef MONOTONIZE_CHECK_EN
  logic         m_mono, c_mono, f_mono;
`endif

  pipelined_monotonize #(.VARS(VARS), .REG_MASK(MASK_MAIN)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_down(in_down),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_down(out_down)
`ifdef MONOTONIZE_CHECK_EN
    , .out_was_mono(m_mono)
`endif
  );

  pipelined_monotonize #(.VARS(VARS), .REG_MASK(MASK_COMB)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_down(c_in_down),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_down(c_out_down)
`ifdef MONOTONIZE_CHECK_EN
    , .out_was_mono(c_mono)
`endif
  );

  pipelined_monotonize #(.VARS(VARS), .REG_MASK(MASK_FULL)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_down(f_in_down),
    .in_data(f_in_data), .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
    .out_down(f_out_down)
`ifdef MONOTONIZE_CHECK_EN
    , .out_was_mono(f_mono)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Brute-force closure: bit i is set when some set bit j is a subset (up) or superset (down) of i.
  function automatic logic [W-1:0] closure(input logic [W-1:0] d, input logic dn);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (d[j] && (dn ? ((i & j) == i) : ((i & j) == j))) r[i] = 1'b1;
    return r;
  endfunction

  typedef struct { logic [W-1:0] data; logic down; } exp_t;
  exp_t         sb[$];
  logic [W-1:0] drv_exp;
  bit           last_in_fire, last_out_fire;
  int           n_out = 0;

  // Evaluates both handshakes mid-cycle, scores any output, then advances one clock.
  task automatic tick();
    exp_t e;
    #1;
    last_out_fire = out_valid && out_ready;
    last_in_fire  = in_valid && in_ready;
    if (last_out_fire) begin
      n_out++;
      if (sb.size() == 0) check("spurious_out", out_valid, 1'b0);
      else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_down", out_down, e.down);
      end
    end
    if (last_in_fire) sb.push_back('{data: drv_exp, down: in_down});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send1(input string tag, input logic [W-1:0] d, input logic dn, input logic [W-1:0] exp);
    int lat;
    in_valid = 1'b1; in_data = d; in_down = dn; drv_exp = exp;
    tick();
    check({tag, "_acc"}, last_in_fire, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!last_out_fire && lat < 20);
    check({tag, "_lat"}, lat, L_MAIN);
    #1 check({tag, "_drop"}, out_valid, 1'b0);
  endtask

  logic [W-1:0] d_tab [4];
  logic         dn_tab[4];
  logic [W-1:0] e_tab [4];
  logic [W-1:0] b5, hold_d;
  int           n_acc, base_out, lat, fires;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    b5 = 128'h20;
    d_tab[0] = 128'h8;          dn_tab[0] = 1'b0; e_tab[0] = {32{4'h8}};
    d_tab[1] = {1'b1, 127'b0};  dn_tab[1] = 1'b1; e_tab[1] = '1;
    d_tab[2] = {1'b1, 127'b0};  dn_tab[2] = 1'b0; e_tab[2] = {1'b1, 127'b0};
    d_tab[3] = 128'h1;          dn_tab[3] = 1'b1; e_tab[3] = 128'h1;

    rst_n = 1'b0; in_valid = 1'b0; in_down = 1'b0; in_data = '0; out_ready = 1'b1; drv_exp = '0;
    c_in_valid = 1'b0; c_in_down = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    f_in_valid = 1'b0; f_in_down = 1'b0; f_in_data = '0; f_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  '0);
    check("rst_out_down",  out_down,  1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_full_valid", f_out_valid, 1'b0);
`ifdef MONOTONIZE_CHECK_EN
    check("rst_mono", m_mono, 1'b0);
`endif

    // Single transactions with hand-computed closures.
    send1("up_bit0", 128'h1, 1'b0, '1);
    send1("up_bit5", b5, 1'b0, {16{8'hA0}});
    send1("dn_bit5", b5, 1'b1, 128'h33);

    // Back-to-back, alternating direction.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = d_tab[i]; in_down = dn_tab[i]; drv_exp = e_tab[i];
      tick();
      check("burst_acc", last_in_fire, 1'b1);
      if (i > 0) check("burst_b2b", last_out_fire, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check("burst_tail", last_out_fire, 1'b1);
    tick();
    check("burst_idle", last_out_fire, 1'b0);
    check("burst_sb_empty", sb.size(), 0);

    // Backpressure: stall output for 10 cycles while offering input.
    base_out = n_out; n_acc = 0; hold_d = '0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_down = 1'b0;
    drv_exp = closure(in_data, in_down);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) hold_d = out_data;
      if (last_in_fire) begin
        n_acc++;
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_down = ~in_down;
        drv_exp = closure(in_data, in_down);
      end
    end
    #1;
    check("bp_accepted", n_acc, L_MAIN);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_valid_held", out_valid, 1'b1);
    check("bp_data_stable", out_data, hold_d);
    out_ready = 1'b1;
    #1 check("bp_pass_through", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_in_fire) begin
        n_acc++;
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_down = ~in_down;
        drv_exp = closure(in_data, in_down);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("bp_drained", sb.size(), 0);
    check("bp_count", n_out - base_out, n_acc);

    // Reset with work in flight: nothing from it may emerge afterwards.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 128'h5; in_down = 1'b0; drv_exp = closure(in_data, 1'b0);
    tick();
    in_data = 128'h9;
    tick();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    fires = 0;
    for (int i = 0; i < 3; i++) begin tick(); fires += int'(last_out_fire); end
    check("mid_rst_silent", fires, 0);
    send1("post_rst", b5, 1'b1, 128'h33);

    // L = 0 instance: purely combinational.
    c_in_valid = 1'b1; c_in_data = 128'h1; c_in_down = 1'b0; c_out_ready = 1'b1;
    #1;
    check("comb_valid", c_out_valid, 1'b1);
    check("comb_data_up", c_out_data, '1);
    check("comb_ready", c_in_ready, 1'b1);
`ifdef MONOTONIZE_CHECK_EN
    check("comb_mono_0", c_mono, 1'b0);
    c_in_data = '1;
    #1 check("comb_mono_1", c_mono, 1'b1);
`endif
    c_out_ready = 1'b0; c_in_data = b5; c_in_down = 1'b1;
    #1;
    check("comb_ready_bp", c_in_ready, 1'b0);
    check("comb_data_dn", c_out_data, 128'h33);
    check("comb_down", c_out_down, 1'b1);
    c_in_valid = 1'b0;
    #1 check("comb_idle", c_out_valid, 1'b0);
    @(negedge clk);

    // Fully registered instance: latency 7.
    f_in_valid = 1'b1; f_in_data = 128'h1; f_in_down = 1'b0;
    #1 check("full_in_ready", f_in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    f_in_valid = 1'b0;
    lat = 1;
    while (!f_out_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
    #1;
    check("full_lat", lat, L_FULL);
    check("full_data", f_out_data, '1);
    check("full_down", f_out_down, 1'b0);
`ifdef MONOTONIZE_CHECK_EN
    check("full_mono_0", f_mono, 1'b0);
    @(negedge clk);
    f_in_valid = 1'b1; f_in_data = '1; f_in_down = 1'b0;
    @(posedge clk); @(negedge clk);
    f_in_valid = 1'b0;
    for (int i = 0; i < 20 && !(f_out_valid && f_out_data == '1); i++) begin @(posedge clk); @(negedge clk); end
    #1 check("full_mono_1", f_mono, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
